// File: rtl/cla_sub16_pipe_if.sv
// Operand/result handshake bundle for the pipelined CLA subtractor.
// master drives operands and out_ready; slave (the subtractor) returns results.
interface cla_sub16_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             neg;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, zero, neg, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, zero, neg, ovf
    );
endinterface

// File: rtl/cla_sub16_pipe.sv
// Two-stage pipelined subtractor: diff = a + ~b + ~bin built from 4-bit
// carry-lookahead groups. Stage 1 resolves the low SPLIT bits, stage 2 the
// rest plus flags. bout is the inverted final carry.
module cla_sub16_pipe #(
    parameter int WIDTH = 16,
    parameter int SPLIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    cla_sub16_pipe_if.slave   bus
);
    localparam int HI  = WIDTH - SPLIT;
    localparam int NGL = SPLIT / 4;
    localparam int NGH = HI / 4;

    // 4-bit lookahead group: returns {carry_out, sum}
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic c0);
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        logic       co;
        g    = x & y;
        p    = x ^ y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return {co, p ^ c};
    endfunction

    logic             s1_valid_q;
    logic [SPLIT-1:0] s1_lo_q,   lo_d;
    logic             s1_c_q,    lo_c_d;
    logic [HI-1:0]    s1_ahi_q;
    logic [HI-1:0]    s1_nbhi_q;

    logic             s2_valid_q;
    logic [WIDTH-1:0] diff_q,    diff_d;
    logic             bout_q,    bout_d;
    logic             zero_q,    zero_d;
    logic             neg_q,     neg_d;
    logic             ovf_q,     ovf_d;
    logic [HI-1:0]    hi_d;
    logic             hi_c_d;

    logic adv1;
    logic adv2;

    // Stage 2 may load whenever it is empty or its result is being taken.
    assign adv2         = ~s2_valid_q | bus.out_ready;
    assign adv1         = ~s1_valid_q | adv2;
    assign bus.in_ready = adv1;

    // Low slice: subtract by adding the complement, carry-in is ~borrow-in.
    always_comb begin : low_slice
        logic       c;
        logic [4:0] r;
        c    = ~bus.bin;
        r    = '0;
        lo_d = '0;
        for (int g = 0; g < NGL; g++) begin
            r              = cla4(bus.a[g*4 +: 4], ~bus.b[g*4 +: 4], c);
            lo_d[g*4 +: 4] = r[3:0];
            c              = r[4];
        end
        lo_c_d = c;
    end

    // High slice completion and flags from the stage-1 snapshot.
    always_comb begin : high_slice
        logic       c;
        logic [4:0] r;
        c    = s1_c_q;
        r    = '0;
        hi_d = '0;
        for (int g = 0; g < NGH; g++) begin
            r              = cla4(s1_ahi_q[g*4 +: 4], s1_nbhi_q[g*4 +: 4], c);
            hi_d[g*4 +: 4] = r[3:0];
            c              = r[4];
        end
        hi_c_d = c;
        diff_d = {hi_d, s1_lo_q};
        bout_d = ~hi_c_d;
        zero_d = ~|diff_d;
        neg_d  = diff_d[WIDTH-1];
        // b's sign bit is recovered from the stored complement
        ovf_d  = (s1_ahi_q[HI-1] ^ ~s1_nbhi_q[HI-1]) & (diff_d[WIDTH-1] ^ s1_ahi_q[HI-1]);
    end

    // Stage 1 register: low-slice result, its carry, and the high operand halves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_lo_q    <= '0;
            s1_c_q     <= 1'b0;
            s1_ahi_q   <= '0;
            s1_nbhi_q  <= '0;
        end else if (adv1) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_lo_q   <= lo_d;
                s1_c_q    <= lo_c_d;
                s1_ahi_q  <= bus.a[WIDTH-1:SPLIT];
                s1_nbhi_q <= ~bus.b[WIDTH-1:SPLIT];
            end
        end
    end

    // Stage 2 register: full result and flags, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            diff_q     <= '0;
            bout_q     <= 1'b0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (adv2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                diff_q <= diff_d;
                bout_q <= bout_d;
                zero_q <= zero_d;
                neg_q  <= neg_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cla_sub16_pipe.sv
// Bench for cla_sub16_pipe: directed corner cases, stall, reset, random traffic.
// Results are packed as {bout, zero, neg, ovf, diff}.
module tb_cla_sub16_pipe;
    logic clk;
    logic rst_n;

    cla_sub16_pipe_if #(.WIDTH(16)) bus ();

    cla_sub16_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [19:0] q[$];
    logic        emitted;
    logic        accepted;
    logic [19:0] last_res;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic bin);
        logic [16:0] r;
        logic        z;
        logic        n;
        logic        v;
        r = {1'b0, a} - {1'b0, b} - {16'b0, bin};
        z = (r[15:0] == 16'h0000);
        n = r[15];
        v = (a[15] != b[15]) && (r[15] != a[15]);
        return {r[16], z, n, v, r[15:0]};
    endfunction

    // One clock: sample at negedge, score handshakes, advance past posedge.
    task automatic step();
        logic [19:0] obs;
        emitted  = 1'b0;
        accepted = 1'b0;
        @(negedge clk);
        obs = {bus.bout, bus.zero, bus.neg, bus.ovf, bus.diff};
        if (q.size() == 0)
            chk("no_stale_out", bus.out_valid, 0);
        else if (bus.out_valid && bus.out_ready) begin
            chk("result", obs, q.pop_front());
            emitted  = 1'b1;
            last_res = obs;
        end else if (bus.out_valid)
            chk("hold", obs, q[0]);
        if (bus.in_valid && bus.in_ready) begin
            q.push_back(ref_model(bus.a, bus.b, bus.bin));
            accepted = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic bin);
        bus.a   = a;
        bus.b   = b;
        bus.bin = bin;
    endtask

    // Single op with a free consumer: check latency and the exact result.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic bin, input logic [19:0] exp);
        int n;
        drive(a, b, bin);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!emitted && n < 8);
        chk({tag, "_latency"}, n, 2);
        chk(tag, last_res, exp);
        step();
        chk({tag, "_valid_drop"}, bus.out_valid, 0);
    endtask

    initial begin
        int idx;
        int cyc;
        int got;
        int acc;
        logic [15:0] ops_a[4];
        logic [15:0] ops_b[4];
        logic        ops_c[4];

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(16'h0, 16'h0, 1'b0);
        last_res = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {bus.out_valid, bus.bout, bus.zero, bus.neg, bus.ovf, bus.diff}, 0);
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", bus.in_ready, 1);

        do_op("t1",      16'h0005, 16'h0003, 1'b0, 20'h00002);
        do_op("t2",      16'h0000, 16'h0001, 1'b0, 20'hAFFFF);
        do_op("t3",      16'h8000, 16'h0001, 1'b0, 20'h17FFF);
        do_op("t4_zero", 16'h1234, 16'h1233, 1'b1, 20'h40000);
        do_op("t4_cross",16'h00FF, 16'hFF00, 1'b1, 20'h801FE);
        do_op("wrap",    16'h0000, 16'hFFFF, 1'b1, 20'hC0000);

        // Stall: four ops offered while the consumer is blocked.
        for (int i = 0; i < 4; i++) begin
            ops_a[i] = 16'($urandom);
            ops_b[i] = 16'($urandom);
            ops_c[i] = 1'($urandom);
        end
        idx = 0;
        acc = 0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive(ops_a[0], ops_b[0], ops_c[0]);
        for (int c = 0; c < 4; c++) begin
            step();
            if (accepted) begin
                acc++;
                idx++;
                drive(ops_a[idx], ops_b[idx], ops_c[idx]);
            end
        end
        chk("t5_accepts", acc, 2);
        chk("t5_in_ready", bus.in_ready, 0);
        chk("t5_out_valid", bus.out_valid, 1);
        chk("t5_held", {bus.bout, bus.zero, bus.neg, bus.ovf, bus.diff},
            ref_model(ops_a[0], ops_b[0], ops_c[0]));
        bus.out_ready = 1'b1;
        cyc = 0;
        got = 0;
        while (got < 4 && cyc < 12) begin
            step();
            cyc++;
            if (accepted) begin
                idx++;
                if (idx < 4) drive(ops_a[idx], ops_b[idx], ops_c[idx]);
                else bus.in_valid = 1'b0;
            end
            if (emitted) got++;
        end
        chk("t5_results", got, 4);
        chk("t5_cycles", cyc, 4);

        // Reset with two ops in flight.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive(16'h4444, 16'h1111, 1'b0);
        step();
        drive(16'h9999, 16'h0001, 1'b1);
        step();
        bus.in_valid = 1'b0;
        chk("t6_full", bus.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_outputs", {bus.out_valid, bus.bout, bus.zero, bus.neg, bus.ovf, bus.diff}, 0);
        q.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (6) step();
        chk("t6_in_ready", bus.in_ready, 1);

        // Random traffic with random backpressure.
        acc = 0;
        cyc = 0;
        while (acc < 10000 && cyc < 40000) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       drive(16'h0000, 16'($urandom), 1'($urandom));
                1:       drive(16'($urandom), 16'hFFFF, 1'($urandom));
                2:       drive(16'h8000, 16'($urandom_range(0, 3)), 1'($urandom));
                default: drive(16'($urandom), 16'($urandom), 1'($urandom));
            endcase
            step();
            if (accepted) acc++;
            cyc++;
            if (q.size() > 2) chk("occupancy", q.size(), 2);
        end
        chk("rand_ops", acc, 10000);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) step();
        chk("drain_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
